// File: rtl/simd_accum.sv
// rtl/simd_accum.sv - SIMD lane accumulator with 4x12 or 2x24 lane split
// Sums (or subtracts) BEATS handshaked input beats per lane and tracks sticky per-lane carry/borrow flags.
module simd_accum #(
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        sub,
  input  logic        in_valid,
  input  logic [47:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic [3:0]  out_carry,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic        sub_q, sub_d;
  logic [47:0] acc_q, acc_d;
  logic [3:0]  carry_q, carry_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [47:0] lane_sum;
  logic [3:0]  lane_cout;
  logic [12:0] t12;
  logic [24:0] t24;

  // Each lane is zero-extended by one bit so the top bit is its own carry/borrow.
  always_comb begin
    lane_sum  = '0;
    lane_cout = '0;
    t12       = '0;
    t24       = '0;
    if (mode_q) begin
      for (int i = 0; i < 2; i++) begin
        t24 = sub_q ? ({1'b0, acc_q[i*24 +: 24]} - {1'b0, in_data[i*24 +: 24]})
                    : ({1'b0, acc_q[i*24 +: 24]} + {1'b0, in_data[i*24 +: 24]});
        lane_sum[i*24 +: 24] = t24[23:0];
        lane_cout[i]         = t24[24];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        t12 = sub_q ? ({1'b0, acc_q[i*12 +: 12]} - {1'b0, in_data[i*12 +: 12]})
                    : ({1'b0, acc_q[i*12 +: 12]} + {1'b0, in_data[i*12 +: 12]});
        lane_sum[i*12 +: 12] = t12[11:0];
        lane_cout[i]         = t12[12];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sub_d   = sub_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          sub_d   = sub;
          acc_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid && in_ready) begin
          acc_d   = lane_sum;
          carry_d = carry_q | lane_cout;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'(BEATS - 1)) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      sub_q   <= 1'b0;
      acc_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sub_q   <= sub_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_carry = carry_q;

endmodule

// File: doc/simd_accum.md
SIMD_ACCUM -- requirements
Module: simd_accum

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning the number of accepted input beats per accumulation (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, which begins an accumulation when the block is in IDLE.
REQ-005 SHALL have port mode, input, 1, the lane split: 0 = FOUR12 (4 x 12-bit lanes), 1 = TWO24 (2 x 24-bit lanes).
REQ-006 SHALL have port sub, input, 1, the operation: 0 = acc + in, 1 = acc - in.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data carries a beat.
REQ-008 SHALL have port in_data, input, 48, the packed lanes; lane i occupies bits [i*W +: W], where W is 12 or 24.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream accepts the result.
REQ-012 SHALL have port out_data, output, 48, the packed per-lane accumulators.
REQ-013 SHALL have port out_carry, output, 4, the sticky per-lane carry (add) or borrow (sub) flags.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, ACC and OUT.
REQ-016 SHALL, in IDLE with start=1, latch mode and sub, clear the accumulator, the flags and the beat counter, and go to ACC.
REQ-017 SHALL ignore start, mode and sub while in ACC or OUT.
REQ-018 SHALL drive in_ready=1 only in ACC; a beat is consumed only when in_valid and in_ready are both 1 in the same cycle.
REQ-019 SHALL update each lane on a consumed beat as acc_lane = (acc_lane +/- in_lane) mod 2^W.
REQ-020 SHALL keep lanes fully isolated: no carry or borrow crosses a lane boundary.
REQ-021 SHALL set out_carry[i] sticky when a lane-i add carries out of bit W-1, or when a lane-i subtract borrows; the flag is not cleared until the next start.
REQ-022 SHALL hold out_carry[3:2] at 0 in TWO24 mode.
REQ-023 SHALL go from ACC to OUT on the BEATS-th consumed beat, with out_valid=1 on the next cycle, which already reflects the final beat.
REQ-024 SHALL, in OUT, hold out_valid, out_data and out_carry stable until out_ready=1.
REQ-025 SHALL, on the OUT cycle with out_ready=1, go to IDLE; start in that same cycle is ignored.
REQ-026 SHALL keep out_data and out_carry holding the last result in IDLE, with out_valid=0.
REQ-027 SHALL let in_valid stay asserted in IDLE or OUT without consuming any beat.

Reset
REQ-028 SHALL, on rst=1 at any time, asynchronously force state IDLE, accumulator 0, out_carry 0, counter 0, and in_ready, out_valid and busy to 0.
REQ-029 SHALL, on reset mid-accumulation, discard the partial result; the next start begins a fresh accumulation.

Verification
REQ-030 SHALL be covered by these directed scenarios (BEATS=4):
- FOUR12 add, four beats of 48'h800FFF002001 -> out_data 48'h000FFC008004, out_carry 4'b1100.
- TWO24 sub, four beats of 48'h100000000001 -> out_data 48'hC00000FFFFFC, out_carry 4'b0011.
- Lane isolation: four beats of 48'h000000000FFF. FOUR12 add -> 48'h000000000FFC, out_carry 4'b0001. TWO24 add -> 48'h000000003FFC, out_carry 4'b0000.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0. out_ready=1 -> IDLE next cycle, busy=0.
- Gapped input: in_valid toggling 1,0,1,0,... -> only handshaked beats counted. start together with in_valid in IDLE -> that beat is not consumed.
- Reset after 2 beats -> out_valid=0, in_ready=0, busy=0 immediately. A new start plus 4 beats of 48'h000000000001 (FOUR12 add) -> 48'h000000000004.
